ahb_sram_slave: RTL and testbench
=================================

Name: ahb_sram_slave

Overview:
- AHB slave (responder) fronting a flop-based word-addressed SRAM. It sits behind the AHB decoder/mux on one HSEL bit.
- Accepts pipelined address/data phases and inserts a configurable number of wait states.
- Returns the two-cycle ERROR response for out-of-range, oversize or misaligned accesses.
- It is the counterpart to the master/arbiter side of the bus, and is the default target for master and bridge verification.

Parameters:
- ADDR_WIDTH, 32, HADDR width (from ahb_params_pkg)
- DATA_WIDTH, 32, HWDATA/HRDATA width; fixed at 32 for this block
- MEM_DEPTH, 1024, number of 32-bit words; byte span is MEM_DEPTH*4
- WAIT_STATES, 1, wait cycles inserted per OKAY transfer (0..7)

Ports:
- HCLK  in  1  bus clock; all logic on the rising edge
- HRESET  in  1  asynchronous, active-high reset
- HSEL  in  1  this slave's select bit
- HADDR  in  ADDR_WIDTH  byte address
- HTRANS  in  2  IDLE=00, BUSY=01, NONSEQ=10, SEQ=11
- HWRITE  in  1  1 = write
- HSIZE  in  3  000 = byte, 001 = half, 010 = word; others are illegal
- HBURST  in  3  ignored (each beat is decoded independently)
- HPROT  in  4  ignored
- HWDATA  in  DATA_WIDTH  write data, valid in the data phase
- HREADY  in  1  bus-wide ready (mux output)
- HREADYOUT  out  1  this slave's ready
- HRESP  out  2  OKAY=00, ERROR=01; RETRY and SPLIT are never driven
- HRDATA  out  DATA_WIDTH  read data

Behaviour:
- Reset values: HREADYOUT=1, HRESP=OKAY, HRDATA=0, state=IDLE, wait counter=0. Memory contents are not reset.
- Asserting HRESET mid-transfer aborts it at once: no memory write occurs and outputs return to reset values asynchronously.
- Address phase is sampled on an edge where HSEL & HREADY & HTRANS[1]. The block latches address, size, write flag and an error flag.
- IDLE/BUSY, or HSEL=0: nothing is latched; the next cycle is zero-wait OKAY.
- Error flag is set when any of these holds:
  - word index HADDR[ADDR_WIDTH-1:2] >= MEM_DEPTH;
  - HSIZE > 010;
  - misaligned: half with HADDR[0]=1, or word with HADDR[1:0]!=0.
- FSM states IDLE, WAIT, ERR1, ERR2:
  - IDLE: on a valid sample with error flag set -> ERR1. With no error: if WAIT_STATES>0 -> WAIT with counter=WAIT_STATES-1; else stay in IDLE and complete the data phase in the next cycle with HREADYOUT=1.
  - WAIT: HREADYOUT=0, HRESP=OKAY. Counter decrements each cycle; at 0 -> IDLE with HREADYOUT=1 (completing cycle).
  - ERR1: HREADYOUT=0, HRESP=ERROR; always -> ERR2.
  - ERR2: HREADYOUT=1, HRESP=ERROR. Any new address phase is sampled here as in IDLE; no new address -> IDLE.
- Completing data-phase cycle (HREADYOUT=1, OKAY):
  - Write: byte lanes selected from latched size/addr[1:0] are written from HWDATA at the edge ending that cycle.
  - Read: HRDATA = mem[latched word index], the full word, valid in that cycle; it is 0 in all other cycles.
  - An errored transfer never writes memory.
- Byte lanes are little-endian: byte n -> HWDATA[8n+7:8n]; half at addr[1] -> bytes {2,3} or {0,1}.
- Back-to-back transfers: a new address may be accepted on the completing edge of the previous data phase. A read following a write to the same word returns the new data, because the write commits on the edge that starts the read's data phase.
- HREADY=0 from another slave: no sample. An in-flight own transfer still advances its own counter.

Decomposition:
- ahb_params_pkg gains:
  - htrans_e, hresp_e and hsize_e enums;
  - slave_state_e {IDLE, WAIT, ERR1, ERR2};
  - the OKAY and ERROR constants.
- Sub-module ahb_byte_strobe_gen: combinational size+addr[1:0] -> 4-bit strobe plus a misalign flag. It is reused by the planned APB bridge.

Test Plan:
- WAIT_STATES=1: NONSEQ write word 0xDEADBEEF @0x10, then NONSEQ read @0x10 -> write gives one HREADYOUT=0 cycle then OKAY; read returns 0xDEADBEEF after one wait.
- Byte writes 0x11 @0x21, then half 0xAABB @0x22; word read @0x20 -> 0xAABB11xx, with byte 0 unchanged from a prior word write of 0 (expect 0xAABB1100).
- Word read @ byte address MEM_DEPTH*4 (0x1000) -> HREADYOUT 0 then 1 with HRESP=ERROR for both cycles; memory unchanged; next OKAY transfer proceeds.
- Half write @0x3 -> two-cycle ERROR, no write; read @0x0 returns the prior value.
- WAIT_STATES=0: four-beat INCR read stream @0x0..0xC -> one beat per cycle, HREADYOUT held 1, all OKAY, correct data.
- Assert HRESET during the WAIT cycle of a write @0x40 -> outputs return to reset values immediately; a subsequent read @0x40 returns the old contents.

Source files
------------

// File: rtl/ahb_params_pkg.sv
// ----------------------------------------------------------------------------
// ahb_params_pkg
// Shared AHB definitions: bus widths, transfer/response/size encodings and the
// state type of the SRAM slave's data-phase FSM.
// ----------------------------------------------------------------------------
package ahb_params_pkg;

    localparam int ADDR_WIDTH = 32;
    localparam int DATA_WIDTH = 32;

    typedef enum logic [1:0] {
        HTRANS_IDLE   = 2'b00,
        HTRANS_BUSY   = 2'b01,
        HTRANS_NONSEQ = 2'b10,
        HTRANS_SEQ    = 2'b11
    } htrans_e;

    typedef enum logic [1:0] {
        HRESP_OKAY  = 2'b00,
        HRESP_ERROR = 2'b01,
        HRESP_RETRY = 2'b10,
        HRESP_SPLIT = 2'b11
    } hresp_e;

    typedef enum logic [2:0] {
        HSIZE_BYTE = 3'b000,
        HSIZE_HALF = 3'b001,
        HSIZE_WORD = 3'b010
    } hsize_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_WAIT = 2'b01,
        ST_ERR1 = 2'b10,
        ST_ERR2 = 2'b11
    } slave_state_e;

    localparam logic [1:0] RESP_OKAY  = 2'b00;
    localparam logic [1:0] RESP_ERROR = 2'b01;

endpackage

// File: rtl/ahb_byte_strobe_gen.sv
// ----------------------------------------------------------------------------
// ahb_byte_strobe_gen
// Maps a transfer size and the low two address bits to little-endian byte
// lane strobes (lane n = data[8n+7:8n]) and flags misaligned accesses.
//   size      in  3  HSIZE encoding (byte/half/word; larger sizes give strb=0)
//   addr_lo   in  2  HADDR[1:0]
//   strb      out 4  byte lanes touched by the access
//   misalign  out 1  half on an odd address, or word not on a 4-byte boundary
// Oversize encodings are not flagged here; the caller checks size on its own.
// ----------------------------------------------------------------------------
module ahb_byte_strobe_gen
    import ahb_params_pkg::*;
(
    input  logic [2:0] size,
    input  logic [1:0] addr_lo,
    output logic [3:0] strb,
    output logic       misalign
);

    always_comb begin
        strb     = 4'b0000;
        misalign = 1'b0;
        if (size == HSIZE_BYTE) begin
            strb = 4'b0001 << addr_lo;
        end else if (size == HSIZE_HALF) begin
            strb     = addr_lo[1] ? 4'b1100 : 4'b0011;
            misalign = addr_lo[0];
        end else if (size == HSIZE_WORD) begin
            strb     = 4'b1111;
            misalign = (addr_lo != 2'b00);
        end
    end

endmodule

// File: rtl/ahb_sram_slave.sv
// ----------------------------------------------------------------------------
// ahb_sram_slave
// AHB slave in front of a flop-based, word-addressed SRAM. Inserts
// WAIT_STATES wait cycles per OKAY transfer and gives the two-cycle ERROR
// response for out-of-range, oversize or misaligned accesses.
//   HCLK       in  1           bus clock (rising edge)
//   HRESET     in  1           asynchronous active-high reset
//   HSEL       in  1           slave select
//   HADDR      in  ADDR_WIDTH  byte address
//   HTRANS     in  2           transfer type (only bit 1 matters here)
//   HWRITE     in  1           1 = write
//   HSIZE      in  3           byte/half/word
//   HBURST     in  3           ignored, every beat is decoded on its own
//   HPROT      in  4           ignored
//   HWDATA     in  DATA_WIDTH  write data (data phase)
//   HREADY     in  1           bus-wide ready
//   HREADYOUT  out 1           this slave's ready
//   HRESP      out 2           OKAY / ERROR
//   HRDATA     out DATA_WIDTH  read data, non-zero only in a read's completing cycle
//   dbg_state  out 2           current FSM state
// Handshake: an address phase is taken on an edge where HSEL & HREADY &
// HTRANS[1]; its data phase ends on the first later edge with HREADYOUT=1.
// ----------------------------------------------------------------------------
module ahb_sram_slave
    import ahb_params_pkg::*;
#(
    parameter int ADDR_WIDTH  = ahb_params_pkg::ADDR_WIDTH,
    parameter int DATA_WIDTH  = 32,
    parameter int MEM_DEPTH   = 1024,
    parameter int WAIT_STATES = 1
) (
    input  logic                  HCLK,
    input  logic                  HRESET,
    input  logic                  HSEL,
    input  logic [ADDR_WIDTH-1:0] HADDR,
    input  logic [1:0]            HTRANS,
    input  logic                  HWRITE,
    input  logic [2:0]            HSIZE,
    input  logic [2:0]            HBURST,
    input  logic [3:0]            HPROT,
    input  logic [DATA_WIDTH-1:0] HWDATA,
    input  logic                  HREADY,
    output logic                  HREADYOUT,
    output logic [1:0]            HRESP,
    output logic [DATA_WIDTH-1:0] HRDATA,
    output slave_state_e          dbg_state
);

    localparam int IDX_W = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
    localparam logic [2:0] WS_LOAD = (WAIT_STATES > 0) ? 3'(WAIT_STATES - 1) : 3'd0;

    slave_state_e state, state_nx;
    logic [2:0]   cnt, cnt_nx;
    logic         pend, pend_nx;     // an OKAY data phase is in flight
    logic         accept;            // latch a good address phase this edge

    logic [IDX_W-1:0] l_idx;
    logic [3:0]       l_strb;
    logic             l_write;

    logic       sample;
    logic       range_err, size_err, misalign, addr_err;
    logic [3:0] strb;
    logic       complete;

    logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];

    logic unused_inputs;
    assign unused_inputs = ^{HBURST, HPROT, HTRANS[0]};

    ahb_byte_strobe_gen u_strobe (
        .size     (HSIZE),
        .addr_lo  (HADDR[1:0]),
        .strb     (strb),
        .misalign (misalign)
    );

    assign sample    = HSEL & HREADY & HTRANS[1];
    assign range_err = {2'b00, HADDR[ADDR_WIDTH-1:2]} >= ADDR_WIDTH'(MEM_DEPTH);
    assign size_err  = (HSIZE > 3'b010);
    assign addr_err  = range_err | size_err | misalign;

    // Completing cycle of an OKAY transfer: only IDLE can hold a pending one,
    // since WAIT always hands over to IDLE for the final ready cycle.
    assign complete  = pend & (state == ST_IDLE);

    always_comb begin
        state_nx  = state;
        cnt_nx    = cnt;
        pend_nx   = pend;
        accept    = 1'b0;
        HREADYOUT = 1'b1;
        HRESP     = RESP_OKAY;
        unique case (state)
            ST_IDLE, ST_ERR2: begin
                if (state == ST_ERR2) begin
                    HRESP = RESP_ERROR;
                end
                state_nx = ST_IDLE;
                pend_nx  = 1'b0;
                if (sample) begin
                    if (addr_err) begin
                        state_nx = ST_ERR1;
                    end else begin
                        accept  = 1'b1;
                        pend_nx = 1'b1;
                        if (WAIT_STATES > 0) begin
                            state_nx = ST_WAIT;
                            cnt_nx   = WS_LOAD;
                        end
                    end
                end
            end
            ST_WAIT: begin
                HREADYOUT = 1'b0;
                if (cnt == 3'd0) begin
                    state_nx = ST_IDLE;
                end else begin
                    cnt_nx = cnt - 3'd1;
                end
            end
            ST_ERR1: begin
                HREADYOUT = 1'b0;
                HRESP     = RESP_ERROR;
                state_nx  = ST_ERR2;
            end
            default: begin
                state_nx = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            state   <= ST_IDLE;
            cnt     <= 3'd0;
            pend    <= 1'b0;
            l_idx   <= '0;
            l_strb  <= 4'b0000;
            l_write <= 1'b0;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
            pend  <= pend_nx;
            if (accept) begin
                l_idx   <= HADDR[IDX_W+1:2];
                l_strb  <= strb;
                l_write <= HWRITE;
            end
        end
    end

    // Memory has no reset. The write lands on the edge that ends the
    // completing cycle, so a read accepted on that same edge sees new data.
    always_ff @(posedge HCLK) begin
        if (!HRESET && complete && l_write) begin
            for (int b = 0; b < 4; b++) begin
                if (l_strb[b]) begin
                    mem[l_idx][8*b +: 8] <= HWDATA[8*b +: 8];
                end
            end
        end
    end

    assign HRDATA    = (complete && !l_write) ? mem[l_idx] : '0;
    assign dbg_state = state;

endmodule

// File: tb/tb_ahb_sram_slave.sv
module tb_ahb_sram_slave;
    import ahb_params_pkg::*;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    // ---------------- shared master-side bus ----------------
    logic        hsel, hwrite, dut_sel;  // dut_sel: 0 = WS=1 instance, 1 = WS=0 instance
    logic [31:0] haddr, hwdata;
    logic [1:0]  htrans;
    logic [2:0]  hsize;

    logic         a_ready, b_ready;
    logic [1:0]   a_resp, b_resp;
    logic [31:0]  a_rdata, b_rdata;
    slave_state_e a_state, b_state;

    logic        hready_bus;
    logic [1:0]  hresp_bus;
    logic [31:0] hrdata_bus;
    assign hready_bus = dut_sel ? b_ready : a_ready;
    assign hresp_bus  = dut_sel ? b_resp  : a_resp;
    assign hrdata_bus = dut_sel ? b_rdata : a_rdata;

    ahb_sram_slave #(.WAIT_STATES(1)) dut_a (
        .HCLK(clk), .HRESET(rst), .HSEL(hsel & ~dut_sel), .HADDR(haddr),
        .HTRANS(htrans), .HWRITE(hwrite), .HSIZE(hsize), .HBURST(3'b001),
        .HPROT(4'b0011), .HWDATA(hwdata), .HREADY(hready_bus),
        .HREADYOUT(a_ready), .HRESP(a_resp), .HRDATA(a_rdata), .dbg_state(a_state)
    );

    ahb_sram_slave #(.WAIT_STATES(0)) dut_b (
        .HCLK(clk), .HRESET(rst), .HSEL(hsel & dut_sel), .HADDR(haddr),
        .HTRANS(htrans), .HWRITE(hwrite), .HSIZE(hsize), .HBURST(3'b001),
        .HPROT(4'b0011), .HWDATA(hwdata), .HREADY(hready_bus),
        .HREADYOUT(b_ready), .HRESP(b_resp), .HRDATA(b_rdata), .dbg_state(b_state)
    );

    // ---------------- bookkeeping ----------------
    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // expected entry: {wait cycles[3:0], resp[1:0], hrdata[31:0]}
    logic [37:0] exp_q[$];

    typedef struct {
        logic [31:0] addr;
        logic [2:0]  size;
        logic        write;
        logic [31:0] wdata;
        logic [1:0]  exp_resp;
        logic [31:0] exp_data;
    } beat_t;
    beat_t bq[$];

    task automatic add_beat(input logic [31:0] addr, input logic [2:0] size, input logic write,
                            input logic [31:0] wdata, input logic [1:0] resp, input logic [31:0] data);
        beat_t b;
        b.addr = addr; b.size = size; b.write = write; b.wdata = wdata;
        b.exp_resp = resp; b.exp_data = data;
        bq.push_back(b);
    endtask

    // ---------------- pipelined driver ----------------
    task automatic run_burst();
        beat_t       cur;
        logic        dp_on, rdy, first;
        logic [31:0] dp_wd;
        logic [3:0]  waits;
        int          guard;
        dp_on = 1'b0; dp_wd = '0; guard = 0; first = 1'b1;
        while ((bq.size() > 0 || dp_on) && guard < 300) begin
            if (bq.size() > 0) begin
                cur    = bq[0];
                hsel   = 1'b1;
                haddr  = cur.addr;
                hsize  = cur.size;
                hwrite = cur.write;
                htrans = first ? HTRANS_NONSEQ : HTRANS_SEQ;
            end else begin
                hsel   = 1'b0;
                htrans = HTRANS_IDLE;
            end
            hwdata = dp_wd;
            @(negedge clk);
            rdy = hready_bus;
            @(posedge clk);
            #1;
            guard++;
            if (rdy) begin
                dp_on = (bq.size() > 0);
                if (dp_on) begin
                    cur   = bq.pop_front();
                    dp_wd = cur.wdata;
                    first = 1'b0;
                    waits = (cur.exp_resp == RESP_ERROR) ? 4'd1 : (dut_sel ? 4'd0 : 4'd1);
                    exp_q.push_back({waits, cur.exp_resp, cur.exp_data});
                end
            end
        end
        if (guard >= 300) begin
            total++; bad++;
            $display("FAIL driver_timeout: got %0d cycles expected < 300", guard);
            bq.delete();
        end
        hsel   = 1'b0;
        htrans = HTRANS_IDLE;
    endtask

    // ---------------- monitor / scoreboard ----------------
    logic        mon_dp = 1'b0;
    logic [3:0]  mon_waits = '0;
    logic [1:0]  mon_wresp = '0;
    int          n_done = 0;

    always @(negedge clk) begin
        logic [37:0] e;
        if (rst) begin
            mon_dp    = 1'b0;
            mon_waits = '0;
        end else begin
            if (mon_dp) begin
                if (!hready_bus) begin
                    mon_waits++;
                    mon_wresp = hresp_bus;
                    if (mon_waits > 4'd12) begin
                        total++; bad++;
                        $display("FAIL mon_timeout: got %0d wait cycles expected <= 12", mon_waits);
                        mon_dp    = 1'b0;
                        mon_waits = '0;
                    end
                end else if (exp_q.size() == 0) begin
                    total++; bad++;
                    $display("FAIL sb_empty: got completion expected none (beat %0d)", n_done);
                    mon_waits = '0;
                end else begin
                    e = exp_q.pop_front();
                    check($sformatf("waits[%0d]", n_done), mon_waits, e[37:34]);
                    check($sformatf("resp[%0d]", n_done), hresp_bus, e[33:32]);
                    check($sformatf("rdata[%0d]", n_done), hrdata_bus, e[31:0]);
                    if (mon_waits != 0)
                        check($sformatf("wresp[%0d]", n_done), mon_wresp, e[33:32]);
                    n_done++;
                    mon_waits = '0;
                end
            end
            if (hready_bus) mon_dp = hsel & htrans[1];
        end
    end

    // ---------------- directed sequence ----------------
    initial begin
        rst = 1'b1; dut_sel = 1'b0; hsel = 1'b0; htrans = HTRANS_IDLE;
        haddr = '0; hwdata = '0; hwrite = 1'b0; hsize = HSIZE_WORD;
        repeat (3) @(posedge clk);
        #1;
        check("rst_a_ready", a_ready, 1'b1);
        check("rst_a_resp",  a_resp, RESP_OKAY);
        check("rst_a_rdata", a_rdata, 32'h0);
        check("rst_a_state", a_state, ST_IDLE);
        check("rst_b_ready", b_ready, 1'b1);
        rst = 1'b0;
        @(posedge clk); #1;

        // write then back-to-back read of the same word
        add_beat(32'h10, HSIZE_WORD, 1'b1, 32'hDEADBEEF, RESP_OKAY, 32'h0);
        add_beat(32'h10, HSIZE_WORD, 1'b0, 32'h0,        RESP_OKAY, 32'hDEADBEEF);
        run_burst();

        // byte and half lanes; junk in unselected lanes must not land
        add_beat(32'h20, HSIZE_WORD, 1'b1, 32'h00000000, RESP_OKAY, 32'h0);
        add_beat(32'h21, HSIZE_BYTE, 1'b1, 32'hFFFF11FF, RESP_OKAY, 32'h0);
        add_beat(32'h22, HSIZE_HALF, 1'b1, 32'hAABB1234, RESP_OKAY, 32'h0);
        add_beat(32'h20, HSIZE_WORD, 1'b0, 32'h0,        RESP_OKAY, 32'hAABB1100);
        run_burst();

        // out of range: first word past the end, read and write
        add_beat(32'h0,    HSIZE_WORD, 1'b1, 32'h5A5A5A5A, RESP_OKAY,  32'h0);
        add_beat(32'h1000, HSIZE_WORD, 1'b0, 32'h0,        RESP_ERROR, 32'h0);
        add_beat(32'h1000, HSIZE_WORD, 1'b1, 32'hBAD0BAD0, RESP_ERROR, 32'h0);
        add_beat(32'h0,    HSIZE_WORD, 1'b0, 32'h0,        RESP_OKAY,  32'h5A5A5A5A);
        run_burst();

        // misaligned and oversize writes are dropped; last word is in range
        add_beat(32'h3,   HSIZE_HALF, 1'b1, 32'hFFFFFFFF, RESP_ERROR, 32'h0);
        add_beat(32'h0,   3'b011,     1'b1, 32'hFFFFFFFF, RESP_ERROR, 32'h0);
        add_beat(32'h2,   HSIZE_WORD, 1'b1, 32'hFFFFFFFF, RESP_ERROR, 32'h0);
        add_beat(32'h0,   HSIZE_WORD, 1'b0, 32'h0,        RESP_OKAY,  32'h5A5A5A5A);
        add_beat(32'hFFC, HSIZE_WORD, 1'b1, 32'hCAFEF00D, RESP_OKAY,  32'h0);
        add_beat(32'hFFC, HSIZE_WORD, 1'b0, 32'h0,        RESP_OKAY,  32'hCAFEF00D);
        add_beat(32'h10,  HSIZE_WORD, 1'b0, 32'h0,        RESP_OKAY,  32'hDEADBEEF);
        run_burst();

        // reset during the wait cycle of a write aborts it
        add_beat(32'h40, HSIZE_WORD, 1'b1, 32'h01020304, RESP_OKAY, 32'h0);
        run_burst();
        hsel = 1'b1; haddr = 32'h40; hsize = HSIZE_WORD; hwrite = 1'b1; htrans = HTRANS_NONSEQ;
        @(posedge clk); #1;
        hsel = 1'b0; htrans = HTRANS_IDLE; hwdata = 32'hFFFFFFFF;
        check("abort_wait_ready", a_ready, 1'b0);
        check("abort_wait_state", a_state, ST_WAIT);
        rst = 1'b1;
        #1;
        check("abort_ready", a_ready, 1'b1);
        check("abort_resp",  a_resp, RESP_OKAY);
        check("abort_rdata", a_rdata, 32'h0);
        check("abort_state", a_state, ST_IDLE);
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        add_beat(32'h40, HSIZE_WORD, 1'b0, 32'h0, RESP_OKAY, 32'h01020304);
        run_burst();

        // zero-wait instance: pipelined writes then a four-beat read stream
        dut_sel = 1'b1;
        @(posedge clk); #1;
        add_beat(32'h0, HSIZE_WORD, 1'b1, 32'h0A0A0A0A, RESP_OKAY, 32'h0);
        add_beat(32'h4, HSIZE_WORD, 1'b1, 32'h1B1B1B1B, RESP_OKAY, 32'h0);
        add_beat(32'h8, HSIZE_WORD, 1'b1, 32'h2C2C2C2C, RESP_OKAY, 32'h0);
        add_beat(32'hC, HSIZE_WORD, 1'b1, 32'h3D3D3D3D, RESP_OKAY, 32'h0);
        run_burst();
        add_beat(32'h0, HSIZE_WORD, 1'b0, 32'h0, RESP_OKAY, 32'h0A0A0A0A);
        add_beat(32'h4, HSIZE_WORD, 1'b0, 32'h0, RESP_OKAY, 32'h1B1B1B1B);
        add_beat(32'h8, HSIZE_WORD, 1'b0, 32'h0, RESP_OKAY, 32'h2C2C2C2C);
        add_beat(32'hC, HSIZE_WORD, 1'b0, 32'h0, RESP_OKAY, 32'h3D3D3D3D);
        run_burst();
        add_beat(32'h5, HSIZE_HALF, 1'b0, 32'h0, RESP_ERROR, 32'h0);
        add_beat(32'h4, HSIZE_WORD, 1'b0, 32'h0, RESP_OKAY,  32'h1B1B1B1B);
        run_burst();

        repeat (4) @(posedge clk);
        #1;
        check("sb_drained", exp_q.size(), 0);
        check("beats_done", n_done, 29);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
